// File: rtl/design_select_sequencer.sv
// rtl/design_select_sequencer.sv - debounced design select with isolated, glitch-free switch-over
module design_select_sequencer #(
    parameter int GPIO_W         = 34,
    parameter int SEL_W          = 4,
    parameter int NUM_DESIGNS    = 16,
    parameter int STABLE_CYCLES  = 8,
    parameter int ISOLATE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [SEL_W-1:0]              design_select,
    input  logic [GPIO_W-1:0]             gpio_in,
    output logic [GPIO_W-1:0]             gpio_out,
    output logic [GPIO_W-1:0]             gpio_oeb,
    input  logic [NUM_DESIGNS*GPIO_W-1:0] des_out,
    input  logic [NUM_DESIGNS*GPIO_W-1:0] des_oeb,
    output logic [NUM_DESIGNS*GPIO_W-1:0] des_in,
    output logic [NUM_DESIGNS-1:0]        des_rst_n,
    output logic [SEL_W-1:0]              active_sel,
    output logic                          active_valid,
    output logic                          switching
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int ISO_W = $clog2(ISOLATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [ISO_W-1:0] ISO_LAST   = ISO_W'(ISOLATE_CYCLES - 1);
    localparam logic [SEL_W:0]   NUM_D      = (SEL_W + 1)'(NUM_DESIGNS);

    typedef enum logic [1:0] {ST_WAIT, ST_ISOLATE, ST_RUN} state_t;

    state_t                   state;
    logic [SEL_W-1:0]         sel_meta;
    logic [SEL_W-1:0]         sel_sync;
    logic [SEL_W-1:0]         candidate;
    logic [CNT_W-1:0]         stab_cnt;
    logic [ISO_W-1:0]         iso_cnt;
    logic                     stable;
    logic                     in_range;
    logic [NUM_DESIGNS-1:0]   sel_onehot;

    assign stable   = (stab_cnt == STABLE_MAX);
    assign in_range = ({1'b0, candidate} < NUM_D);

    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            sel_onehot[k] = (SEL_W'(k) == active_sel);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_meta  <= '0;
            sel_sync  <= '0;
            candidate <= '0;
            stab_cnt  <= '0;
        end else begin
            sel_meta <= design_select;
            sel_sync <= sel_meta;
            if (sel_sync != candidate) begin
                candidate <= sel_sync;
                stab_cnt  <= '0;
            end else if (stab_cnt != STABLE_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Control outputs are updated on the same edge as the state, so they never lag it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_WAIT;
            active_sel   <= '0;
            iso_cnt      <= '0;
            des_rst_n    <= '0;
            active_valid <= 1'b0;
            switching    <= 1'b1;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (stable && in_range) begin
                        active_sel <= candidate;
                        iso_cnt    <= '0;
                        state      <= ST_ISOLATE;
                    end
                end
                ST_ISOLATE: begin
                    if (candidate != active_sel) begin
                        state <= ST_WAIT;
                    end else if (iso_cnt == ISO_LAST) begin
                        state        <= ST_RUN;
                        des_rst_n    <= sel_onehot;
                        active_valid <= 1'b1;
                        switching    <= 1'b0;
                    end else begin
                        iso_cnt <= iso_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stable && candidate != active_sel) begin
                        state        <= ST_WAIT;
                        des_rst_n    <= '0;
                        active_valid <= 1'b0;
                        switching    <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_WAIT;
                    des_rst_n    <= '0;
                    active_valid <= 1'b0;
                    switching    <= 1'b1;
                end
            endcase
        end
    end

    // Pad datapath is gated only by registered control, so a select change cannot glitch it.
    always_comb begin
        gpio_out = '0;
        gpio_oeb = '1;
        des_in   = '0;
        if (active_valid) begin
            for (int k = 0; k < NUM_DESIGNS; k++) begin
                if (sel_onehot[k]) begin
                    gpio_out                  = des_out[k*GPIO_W +: GPIO_W];
                    gpio_oeb                  = des_oeb[k*GPIO_W +: GPIO_W];
                    des_in[k*GPIO_W +: GPIO_W] = gpio_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_design_select_sequencer.sv
// tb/tb_design_select_sequencer.sv - scoreboard bench for design_select_sequencer
module tb_design_select_sequencer;
    localparam int G  = 34;
    localparam int S  = 4;
    localparam int N  = 16;
    localparam int NB = 12;

    typedef struct {
        logic [N-1:0] mask;
        int           latency;
    } exp_t;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [S-1:0]   design_select;
    logic [G-1:0]   gpio_in;
    logic [G-1:0]   gpio_out;
    logic [G-1:0]   gpio_oeb;
    logic [N*G-1:0] des_out;
    logic [N*G-1:0] des_oeb;
    logic [N*G-1:0] des_in;
    logic [N-1:0]   des_rst_n;
    logic [S-1:0]   active_sel;
    logic           active_valid;
    logic           switching;

    logic            n_rst_b;
    logic [S-1:0]    sel_b;
    logic [G-1:0]    gpio_out_b;
    logic [G-1:0]    gpio_oeb_b;
    logic [NB*G-1:0] des_out_b;
    logic [NB*G-1:0] des_oeb_b;
    logic [NB*G-1:0] des_in_b;
    logic [NB-1:0]   des_rst_n_b;
    logic [S-1:0]    active_sel_b;
    logic            active_valid_b;
    logic            switching_b;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    design_select_sequencer u_dut (
        .clk(clk), .n_rst(n_rst), .design_select(design_select), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .des_out(des_out), .des_oeb(des_oeb),
        .des_in(des_in), .des_rst_n(des_rst_n), .active_sel(active_sel),
        .active_valid(active_valid), .switching(switching)
    );

    design_select_sequencer #(.NUM_DESIGNS(NB)) u_dut_b (
        .clk(clk), .n_rst(n_rst_b), .design_select(sel_b), .gpio_in(gpio_in),
        .gpio_out(gpio_out_b), .gpio_oeb(gpio_oeb_b), .des_out(des_out_b), .des_oeb(des_oeb_b),
        .des_in(des_in_b), .des_rst_n(des_rst_n_b), .active_sel(active_sel_b),
        .active_valid(active_valid_b), .switching(switching_b)
    );

    function automatic logic [G-1:0] pat_out(input int k);
        return {2'b10, 16'(k * 16'h1111), 16'(16'hA500 + k)};
    endfunction

    function automatic logic [G-1:0] pat_oeb(input int k);
        return {30'h0, 4'(k)};
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; n_rst_b = 1'b0;
        design_select = 4'd3; sel_b = 4'd14;
        repeat (3) @(negedge clk);
        checks++; if (des_rst_n !== 16'h0) begin errors++; $display("FAIL reset_des_rst_n got %h exp 0000", des_rst_n); end
        checks++; if (active_valid !== 1'b0) begin errors++; $display("FAIL reset_active_valid got %b exp 0", active_valid); end
        checks++; if (switching !== 1'b1) begin errors++; $display("FAIL reset_switching got %b exp 1", switching); end
        checks++; if (gpio_oeb !== {G{1'b1}}) begin errors++; $display("FAIL reset_gpio_oeb got %h exp all ones", gpio_oeb); end
        checks++; if (gpio_out !== '0) begin errors++; $display("FAIL reset_gpio_out got %h exp 0", gpio_out); end
        checks++; if (des_in !== '0) begin errors++; $display("FAIL reset_des_in got nonzero exp 0"); end
        checks++; if (active_sel !== 4'd0) begin errors++; $display("FAIL reset_active_sel got %0d exp 0", active_sel); end
    endtask

    task automatic test_bringup();
        int n = 41;
        bit early = 0;
        exp_t e;
        logic [N*G-1:0] exp_in;
        sb.push_back('{mask: 16'h0008, latency: 16});
        n_rst = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (active_valid) begin n = i; break; end
            if (gpio_oeb !== {G{1'b1}} || des_rst_n !== 16'h0) early = 1;
        end
        e = sb.pop_front();
        exp_in = '0;
        exp_in[3*G +: G] = gpio_in;
        checks++; if (early) begin errors++; $display("FAIL bringup_highz pads driven before release"); end
        checks++; if (n !== e.latency) begin errors++; $display("FAIL bringup_latency got %0d exp %0d", n, e.latency); end
        checks++; if (des_rst_n !== e.mask) begin errors++; $display("FAIL bringup_des_rst_n got %h exp %h", des_rst_n, e.mask); end
        checks++; if (gpio_out !== pat_out(3)) begin errors++; $display("FAIL bringup_gpio_out got %h exp %h", gpio_out, pat_out(3)); end
        checks++; if (gpio_oeb !== pat_oeb(3)) begin errors++; $display("FAIL bringup_gpio_oeb got %h exp %h", gpio_oeb, pat_oeb(3)); end
        checks++; if (des_in !== exp_in) begin errors++; $display("FAIL bringup_des_in slice routing wrong"); end
        checks++; if (switching !== 1'b0) begin errors++; $display("FAIL bringup_switching got %b exp 0", switching); end
    endtask

    task automatic test_glitch();
        int bad = 0;
        design_select = 4'd5;
        repeat (4) @(negedge clk);
        design_select = 4'd3;
        repeat (30) begin
            @(negedge clk);
            if (!active_valid || gpio_oeb !== pat_oeb(3) || gpio_out !== pat_out(3) || des_rst_n !== 16'h0008) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_ignored got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_switch();
        int fall = 0;
        int off = 1;
        int bad = 0;
        exp_t e;
        design_select = 4'd5;
        sb.push_back('{mask: 16'h0020, latency: 5});
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!active_valid) begin fall = i; break; end
        end
        checks++; if (fall != 12) begin errors++; $display("FAIL switch_fall got %0d exp 12", fall); end
        if (gpio_oeb !== {G{1'b1}} || des_rst_n !== 16'h0) bad++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (active_valid) break;
            off++;
            if (gpio_oeb !== {G{1'b1}} || des_rst_n !== 16'h0 || gpio_out !== '0) bad++;
        end
        e = sb.pop_front();
        checks++; if (bad != 0) begin errors++; $display("FAIL switch_isolation got %0d bad cycles exp 0", bad); end
        checks++; if (off != e.latency) begin errors++; $display("FAIL switch_off_cycles got %0d exp %0d", off, e.latency); end
        checks++; if (des_rst_n !== e.mask) begin errors++; $display("FAIL switch_des_rst_n got %h exp %h", des_rst_n, e.mask); end
        checks++; if (gpio_out !== pat_out(5)) begin errors++; $display("FAIL switch_gpio_out got %h exp %h", gpio_out, pat_out(5)); end
    endtask

    task automatic test_abort();
        int fall = 0;
        int n = 41;
        bit saw6 = 0;
        exp_t e;
        design_select = 4'd6;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!active_valid) begin fall = i; break; end
        end
        checks++; if (fall != 12) begin errors++; $display("FAIL abort_fall got %0d exp 12", fall); end
        @(negedge clk);
        checks++; if (active_sel !== 4'd6 || switching !== 1'b1) begin errors++; $display("FAIL abort_isolate got sel %0d sw %b exp sel 6 sw 1", active_sel, switching); end
        design_select = 4'd2;
        sb.push_back('{mask: 16'h0004, latency: 16});
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (des_rst_n[6]) saw6 = 1;
            if (active_valid) begin n = i; break; end
        end
        e = sb.pop_front();
        checks++; if (saw6) begin errors++; $display("FAIL abort_no_release6 got released exp never"); end
        checks++; if (n != e.latency) begin errors++; $display("FAIL abort_latency got %0d exp %0d", n, e.latency); end
        checks++; if (des_rst_n !== e.mask) begin errors++; $display("FAIL abort_des_rst_n got %h exp %h", des_rst_n, e.mask); end
    endtask

    task automatic test_out_of_range();
        int bad = 0;
        n_rst_b = 1'b0; sel_b = 4'd14;
        @(negedge clk);
        n_rst_b = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!switching_b || active_valid_b || des_rst_n_b !== '0 || gpio_oeb_b !== {G{1'b1}}) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL out_of_range_wait got %0d bad cycles exp 0", bad); end
        checks++; if (des_in_b !== '0) begin errors++; $display("FAIL out_of_range_des_in got nonzero exp 0"); end
    endtask

    task automatic test_async_reset();
        checks++; if (active_valid !== 1'b1) begin errors++; $display("FAIL async_pre_run got %b exp 1", active_valid); end
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        checks++; if (des_rst_n !== 16'h0) begin errors++; $display("FAIL async_des_rst_n got %h exp 0000", des_rst_n); end
        checks++; if (active_valid !== 1'b0 || switching !== 1'b1) begin errors++; $display("FAIL async_flags got av %b sw %b exp 0 1", active_valid, switching); end
        checks++; if (gpio_oeb !== {G{1'b1}} || gpio_out !== '0) begin errors++; $display("FAIL async_pads got oeb %h out %h exp high-Z", gpio_oeb, gpio_out); end
        checks++; if (des_in !== '0 || active_sel !== 4'd0) begin errors++; $display("FAIL async_des_in_sel got sel %0d exp 0 and des_in 0", active_sel); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        gpio_in = 34'h2_DEAD_BEEF;
        for (int k = 0; k < N; k++) begin
            des_out[k*G +: G] = pat_out(k);
            des_oeb[k*G +: G] = pat_oeb(k);
        end
        for (int k = 0; k < NB; k++) begin
            des_out_b[k*G +: G] = pat_out(k);
            des_oeb_b[k*G +: G] = pat_oeb(k);
        end
        test_reset();
        test_bringup();
        test_glitch();
        test_switch();
        test_abort();
        test_out_of_range();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
